// File: rtl/cnn_pkg.sv
// Shared CNN definitions: tap/word/sum widths, the weight-fetch FSM state
// type and the 9-tap adder tree used when WT_FETCH_SUM_EN is defined.
package cnn_pkg;

    localparam int TAP_W    = 16;
    localparam int NUM_TAPS = 9;
    localparam int WORD_W   = 144;
    localparam int SUM_W    = 20;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2
    } fetch_state_e;

    // Sign-extend each tap to SUM_W and add them as a balanced tree; the
    // modulo-2^SUM_W arithmetic gives the correct signed result.
    function automatic logic [SUM_W-1:0] tap_sum(input logic [WORD_W-1:0] w);
        logic [SUM_W-1:0] ext [NUM_TAPS];
        logic [SUM_W-1:0] lvl1 [4];
        logic [SUM_W-1:0] lvl2 [2];
        for (int t = 0; t < NUM_TAPS; t++) begin
            ext[t] = {{(SUM_W-TAP_W){w[WORD_W-1-TAP_W*t]}}, w[WORD_W-1-TAP_W*t -: TAP_W]};
        end
        for (int i = 0; i < 4; i++) begin
            lvl1[i] = ext[2*i] + ext[2*i+1];
        end
        lvl2[0] = lvl1[0] + lvl1[1];
        lvl2[1] = lvl1[2] + lvl1[3];
        return lvl2[0] + lvl2[1] + ext[NUM_TAPS-1];
    endfunction

endpackage

// File: rtl/wt_fifo.sv
// Synchronous FIFO with push/pop, full/empty flags and an occupancy count.
// Push is ignored when full, pop is ignored when empty; a simultaneous push
// and pop leaves the count unchanged. Head data is read combinationally.
module wt_fifo #(
    parameter int WIDTH = 144,
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push,
    input  logic [WIDTH-1:0]        din,
    input  logic                    pop,
    output logic [WIDTH-1:0]        dout,
    output logic                    full,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign dout    = mem[rd_ptr];

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage array; contents need no reset because count gates validity.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/wt_fetch.sv
// Weight fetcher: streams num_words 3x3 kernels from a synchronous weight
// ROM (1-cycle read latency) starting at base_addr, wrapping modulo DEPTH,
// into a small output FIFO with valid/ready flow control.
// Optional feature macro: WT_FETCH_SUM_EN -- when defined, each FIFO entry
// also carries the signed sum of its 9 taps, presented on wt_sum.
//
// Handshake: a kernel moves to the consumer on every rising edge where
// wt_valid and wt_ready are both high; wt_valid never depends on wt_ready,
// and wt_tap/wt_sum stay stable while wt_valid is high and wt_ready is low.
module wt_fetch
    import cnn_pkg::*;
#(
    parameter int ADDR_WIDTH = 11,
    parameter int DEPTH      = 76,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH-1:0] num_words,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [WORD_W-1:0]     rom_q,
    output logic                  wt_valid,
    input  logic                  wt_ready,
    output logic [WORD_W-1:0]     wt_tap,
    output logic [SUM_W-1:0]      wt_sum,
    output logic                  busy,
    output logic                  done
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W:0] OCC_LIMIT = (CNT_W+1)'(FIFO_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

`ifdef WT_FETCH_SUM_EN
    localparam int ENTRY_W = WORD_W + SUM_W;
`else
    localparam int ENTRY_W = WORD_W;
`endif

    fetch_state_e          state;
    logic [ADDR_WIDTH-1:0] remaining;   // reads still to issue
    logic                  rd_v1;       // read issued last edge, ROM sampling it now
    logic                  rd_v2;       // rom_q valid now, pushed at next edge
    logic [CNT_W-1:0]      fifo_count;
    logic [CNT_W:0]        occupancy;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  accept_job;
    logic                  issue_fetch;
    logic                  pop;
    logic [ADDR_WIDTH-1:0] next_addr;
    logic [ENTRY_W-1:0]    push_data;
    logic [ENTRY_W-1:0]    head_data;

    // The first read is issued on the edge that accepts start, which is what
    // gives the 2-cycle start-to-wt_valid latency. Later reads are issued in
    // FETCH only while buffered plus in-flight words leave room in the FIFO,
    // so a push can never meet a full FIFO.
    assign accept_job  = (state == ST_IDLE) && start && (num_words != '0);
    assign occupancy   = (CNT_W+1)'(fifo_count) + (CNT_W+1)'(rd_v1) + (CNT_W+1)'(rd_v2);
    assign issue_fetch = (state == ST_FETCH) && !fifo_full && (occupancy < OCC_LIMIT);
    assign next_addr   = (rom_addr == LAST_ADDR) ? '0 : rom_addr + ADDR_WIDTH'(1);

    assign busy     = (state != ST_IDLE);
    assign wt_valid = !fifo_empty;
    assign pop      = wt_valid && wt_ready;

    // Job control FSM, read address generation and the read-valid pipeline.
    // base_addr is expected below DEPTH; the latched job lives in rom_addr
    // and remaining, which only change in IDLE on start or on an issued read.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            remaining <= '0;
            rom_addr  <= '0;
            rd_v1     <= 1'b0;
            rd_v2     <= 1'b0;
            done      <= 1'b0;
        end else begin
            done  <= 1'b0;
            rd_v1 <= accept_job || issue_fetch;
            rd_v2 <= rd_v1;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        if (num_words == '0) begin
                            done <= 1'b1;
                        end else begin
                            rom_addr  <= base_addr;
                            remaining <= num_words - ADDR_WIDTH'(1);
                            state     <= (num_words == ADDR_WIDTH'(1)) ? ST_DRAIN : ST_FETCH;
                        end
                    end
                end
                ST_FETCH: begin
                    if (issue_fetch) begin
                        rom_addr  <= next_addr;
                        remaining <= remaining - ADDR_WIDTH'(1);
                        if (remaining == ADDR_WIDTH'(1)) state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (fifo_empty && !rd_v1 && !rd_v2) begin
                        state <= ST_IDLE;
                        done  <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef WT_FETCH_SUM_EN
    // The tap sum is formed as the word arrives and captured with it.
    assign push_data = {tap_sum(rom_q), rom_q};
    assign wt_tap    = head_data[WORD_W-1:0];
    assign wt_sum    = head_data[ENTRY_W-1 -: SUM_W];
`else
    assign push_data = rom_q;
    assign wt_tap    = head_data;
    assign wt_sum    = '0;
`endif

    wt_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rd_v2),
        .din   (push_data),
        .pop   (pop),
        .dout  (head_data),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

endmodule

// File: tb/tb_wt_fetch.sv
// Directed bench for wt_fetch with a synchronous ROM model and an
// in-order scoreboard of expected kernels.
module tb_wt_fetch;

    localparam int AW    = 11;
    localparam int DEP   = 76;
    localparam int FDEP  = 4;

    logic          clk;
    logic          rst;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW-1:0] num_words;
    logic [AW-1:0] rom_addr;
    logic [143:0]  rom_q;
    logic          wt_valid;
    logic          wt_ready;
    logic [143:0]  wt_tap;
    logic [19:0]   wt_sum;
    logic          busy;
    logic          done;

    logic [143:0]  rom_img [DEP];
    logic [143:0]  exp_q [$];

    int n_total;
    int n_bad;
    int cyc;
    int done_cnt;
    int xfer_cnt;
    bit rand_ready;

    wt_fetch #(
        .ADDR_WIDTH (AW),
        .DEPTH      (DEP),
        .FIFO_DEPTH (FDEP)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .num_words (num_words),
        .rom_addr  (rom_addr),
        .rom_q     (rom_q),
        .wt_valid  (wt_valid),
        .wt_ready  (wt_ready),
        .wt_tap    (wt_tap),
        .wt_sum    (wt_sum),
        .busy      (busy),
        .done      (done)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", n_total, n_bad);
        $fatal(1);
    end

    // synchronous ROM: data for rom_addr appears one cycle later
    always @(posedge clk) rom_q <= rom_img[rom_addr];

    task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [19:0] model_sum(input logic [143:0] w);
        int s;
        s = 0;
        for (int t = 0; t < 9; t++) s += int'($signed(w[143-16*t -: 16]));
        return 20'(s);
    endfunction

    function automatic logic [19:0] exp_sum(input logic [143:0] w);
`ifdef WT_FETCH_SUM_EN
        return model_sum(w);
`else
        return (w == '0) ? 20'd0 : 20'd0;
`endif
    endfunction

    // scoreboard: every transfer must match the next expected ROM word
    always @(negedge clk) begin
        if (!rst) begin
            if (done) done_cnt++;
            if (wt_valid && wt_ready) begin
                logic [143:0] w;
                xfer_cnt++;
                check("sb_has_word", 160'(exp_q.size() != 0), 160'(1));
                if (exp_q.size() != 0) begin
                    w = exp_q.pop_front();
                    check("xfer_tap", 160'(wt_tap), 160'(w));
                    check("xfer_sum", 160'(wt_sum), 160'(exp_sum(w)));
                end
            end
        end
    end

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (rand_ready) wt_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic start_job(input int base, input int num);
        for (int i = 0; i < num; i++) exp_q.push_back(rom_img[(base + i) % DEP]);
        base_addr = AW'(base);
        num_words = AW'(num);
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(input int limit, output int lat, input int t0);
        int n;
        n = 0;
        while (!done && n < limit) begin
            step();
            n++;
        end
        lat = cyc - t0;
        check("done_seen", 160'(done), 160'(1));
        check("busy_at_done", 160'(busy), 160'(0));
        step();
        check("done_pulse", 160'(done), 160'(0));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        exp_q.delete();
    endtask

    int t0;
    int lat;
    int x0;

    initial begin
        logic [143:0] w;
        n_total = 0; n_bad = 0; cyc = 0; done_cnt = 0; xfer_cnt = 0;
        rand_ready = 1'b0;
        rst = 1'b1; start = 1'b0; base_addr = '0; num_words = '0; wt_ready = 1'b1;

        rom_img[0] = {16'h177b, {6{16'h11d6}}, 16'h11da, 16'hf9b2};
        for (int a = 1; a < DEP; a++) begin
            for (int t = 0; t < 9; t++) w[143-16*t -: 16] = 16'((a * 2711) ^ (t * 40503) ^ 16'h5a3c);
            rom_img[a] = w;
        end

        // reset values
        do_reset();
        check("rst_rom_addr", 160'(rom_addr), 160'(0));
        check("rst_valid", 160'(wt_valid), 160'(0));
        check("rst_busy", 160'(busy), 160'(0));
        check("rst_done", 160'(done), 160'(0));

        // single word from address 0
        start_job(0, 1);
        t0 = cyc;
        check("j1_addr", 160'(rom_addr), 160'(0));
        check("j1_busy", 160'(busy), 160'(1));
        step();
        check("j1_valid_lat1", 160'(wt_valid), 160'(0));
        step();
        check("j1_valid_lat2", 160'(wt_valid), 160'(1));
        check("j1_tap0", 160'(wt_tap[143:128]), 160'(16'h177b));
        check("j1_tap8", 160'(wt_tap[15:0]), 160'(16'hf9b2));
`ifdef WT_FETCH_SUM_EN
        check("j1_sum", 160'(wt_sum), 160'(20'd36363));
`else
        check("j1_sum", 160'(wt_sum), 160'(20'd0));
`endif
        wait_done(20, lat, t0);
        check("j1_done_lat", 160'(lat), 160'(4));

        // wrap-around 74,75,0,1 at full throughput
        start_job(74, 4);
        t0 = cyc;
        x0 = xfer_cnt;
        check("j2_addr0", 160'(rom_addr), 160'(74));
        step(); check("j2_addr1", 160'(rom_addr), 160'(75));
        step(); check("j2_addr2", 160'(rom_addr), 160'(0));
        step(); check("j2_addr3", 160'(rom_addr), 160'(1));
        step(); check("j2_addr_hold", 160'(rom_addr), 160'(1));
        wait_done(20, lat, t0);
        check("j2_done_lat", 160'(lat), 160'(7));
        check("j2_xfers", 160'(xfer_cnt - x0), 160'(4));

        // back-pressure: consumer stalled for 20 cycles
        wt_ready = 1'b0;
        start_job(0, 10);
        t0 = cyc;
        x0 = xfer_cnt;
        for (int i = 0; i < 20; i++) step();
        check("j3_stall_addr", 160'(rom_addr), 160'(FDEP - 1));
        check("j3_stall_valid", 160'(wt_valid), 160'(1));
        check("j3_stall_busy", 160'(busy), 160'(1));
        wt_ready = 1'b1;
        wait_done(100, lat, t0);
        check("j3_xfers", 160'(xfer_cnt - x0), 160'(10));
        check("j3_sb_empty", 160'(exp_q.size()), 160'(0));

        // zero-length job
        start_job(5, 0);
        check("j4_done", 160'(done), 160'(1));
        check("j4_busy", 160'(busy), 160'(0));
        check("j4_valid", 160'(wt_valid), 160'(0));
        step();
        check("j4_done_pulse", 160'(done), 160'(0));
        check("j4_valid_after", 160'(wt_valid), 160'(0));

        // reset in the middle of an 8-word job
        start_job(5, 8);
        step(); step(); step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_q.delete();
        check("j5_rst_addr", 160'(rom_addr), 160'(0));
        check("j5_rst_valid", 160'(wt_valid), 160'(0));
        check("j5_rst_busy", 160'(busy), 160'(0));
        check("j5_rst_done", 160'(done), 160'(0));
        step();
        check("j5_no_late_push", 160'(wt_valid), 160'(0));
        start_job(20, 3);
        t0 = cyc;
        x0 = xfer_cnt;
        wait_done(30, lat, t0);
        check("j5_new_lat", 160'(lat), 160'(6));
        check("j5_new_xfers", 160'(xfer_cnt - x0), 160'(3));

        // random ready with a start pulsed while busy
        rand_ready = 1'b1;
        start_job(60, 20);
        t0 = cyc;
        x0 = xfer_cnt;
        for (int i = 0; i < 5; i++) step();
        check("j6_busy", 160'(busy), 160'(1));
        base_addr = AW'(0);
        num_words = AW'(3);
        start = 1'b1;
        step();
        start = 1'b0;
        wait_done(400, lat, t0);
        rand_ready = 1'b0;
        wt_ready = 1'b1;
        step(); step(); step();
        check("j6_idle_busy", 160'(busy), 160'(0));
        check("j6_idle_valid", 160'(wt_valid), 160'(0));
        check("j6_xfers", 160'(xfer_cnt - x0), 160'(20));

        // final report
        check("sb_drained", 160'(exp_q.size()), 160'(0));
        check("done_count", 160'(done_cnt), 160'(6));
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/wt_fetch.md
WT_FETCH -- requirements
Module: wt_fetch

Interface
REQ-001 Parameter ADDR_WIDTH, default 11, weight ROM address width.
REQ-002 Parameter DEPTH, default 76, number of valid ROM words; addresses wrap modulo DEPTH.
REQ-003 Parameter FIFO_DEPTH, default 4, output buffer entries (power of two, at least 2).
REQ-004 clk  in  1  single clock; all logic on posedge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 start  in  1  one-cycle request; sampled only in IDLE.
REQ-007 base_addr  in  ADDR_WIDTH  first word index, latched on accepted start.
REQ-008 num_words  in  ADDR_WIDTH  words to fetch, latched on accepted start.
REQ-009 rom_addr  out  ADDR_WIDTH  address to weight ROM read port.
REQ-010 rom_q  in  144  ROM data, valid exactly 1 cycle after rom_addr is presented.
REQ-011 wt_valid  out  1  buffer head holds a kernel.
REQ-012 wt_ready  in  1  consumer accepts; transfer when wt_valid and wt_ready.
REQ-013 wt_tap  out  144  9 signed 16-bit taps, row-major, tap t = rom_q[143-16t -: 16].
REQ-014 wt_sum  out  20  signed sum of the 9 head taps (see Configuration).
REQ-015 busy  out  1  high from accepted start until done.
REQ-016 done  out  1  one-cycle pulse at job completion.

Function
REQ-017 FSM states: IDLE, FETCH, DRAIN.
REQ-018 IDLE to FETCH on start with num_words > 0; start with num_words == 0 pulses done the next cycle, issues no reads, and remains in IDLE.
REQ-019 start while busy is ignored and SHALL NOT alter the latched job.
REQ-020 In FETCH, issue one read per cycle only when fifo_count + inflight < FIFO_DEPTH; the address advances by 1 per issued read and wraps from DEPTH-1 to 0.
REQ-021 Each issued read writes rom_q into the FIFO exactly 1 cycle later; no word is dropped or duplicated under any wt_ready pattern.
REQ-022 FETCH to DRAIN in the cycle the num_words-th read is issued.
REQ-023 DRAIN to IDLE when the FIFO is empty and no read is in flight; done pulses in that same cycle and busy falls.
REQ-024 Simultaneous FIFO push and pop SHALL leave fifo_count unchanged.
REQ-025 Full throughput: with wt_ready held at 1, one kernel per cycle after an initial latency of 2 cycles from start to first wt_valid.
REQ-026 rom_addr holds its last value when no read is issued.
REQ-027 wt_tap and wt_sum are driven from the FIFO head, with no added latency relative to wt_valid.

Reset
REQ-028 rst forces IDLE, fifo_count = 0, inflight = 0, rom_addr = 0, wt_valid = 0, busy = 0, done = 0.
REQ-029 rst mid-job discards all buffered and in-flight data; rom_q arriving in the cycle after rst SHALL NOT be written.

Configuration
REQ-030 Macro WT_FETCH_SUM_EN defined: wt_sum is the 20-bit sign-extended sum of the 9 head taps, computed by a registered adder tree at push time and stored alongside each FIFO entry.
REQ-031 Macro WT_FETCH_SUM_EN undefined: wt_sum is tied to 0, no adder logic is built, and the port list is unchanged.

Structure
REQ-032 Shared package cnn_pkg holds TAP_W = 16, NUM_TAPS = 9, WORD_W = 144, SUM_W = 20, and the FSM state enum.
REQ-033 One sub-module, wt_fifo (synchronous FIFO with push, pop, full, empty, and count), instantiated once.

Verification
REQ-034 rst, then start with base = 0 and num = 1 -> rom_addr = 0, then wt_valid with tap0 = 0x177b and tap8 = 0xf9b2; with the macro, wt_sum = 36363; done pulses after the pop.
REQ-035 base = 74 and num = 4 with wt_ready = 1 -> addresses 74, 75, 0, 1 issued in consecutive cycles; 4 transfers in order; done once.
REQ-036 base = 0, num = 10, wt_ready = 0 for 20 cycles then 1 -> at most FIFO_DEPTH reads outstanding, stall with no loss, 10 words delivered in address order.
REQ-037 start with num = 0 -> done the next cycle, busy never high, no wt_valid.
REQ-038 rst asserted 3 cycles into a num = 8 job -> next cycle all outputs at reset values; a new job then runs cleanly.
REQ-039 Random wt_ready plus a second start pulsed while busy -> ignored; the scoreboard matches the ROM image word for word.
